// File: rtl/mult_arb_pkg.sv
// Shared types and constants for the multiplier-sharing arbiter.
package mult_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } arb_state_t;

  localparam int OP_W               = 8;
  localparam int RES_W              = 16;
  localparam int DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first requester at or after last+1, wrapping.
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] req,
  input  logic [2:0]   last,
  output logic [N-1:0] gnt,
  output logic [2:0]   idx,
  output logic         any
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int c;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!any && req[c[IW-1:0]]) begin
        any             = 1'b1;
        gnt[c[IW-1:0]] = 1'b1;
        idx             = 3'(c);
      end
    end
  end

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 8x8 pipelined multiplier between N_REQ requesters, round-robin.
// Optional WAIT watchdog enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arbiter
  import mult_arb_pkg::*;
#(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [OP_W*N_REQ-1:0] req_a,
  input  logic [OP_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]      req_ready,
  output logic [N_REQ-1:0]      rsp_valid,
  output logic [RES_W-1:0]      rsp_result,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [2:0]            grant_id,
  output logic                  mult_St,
  output logic [OP_W-1:0]       mult_A,
  output logic [OP_W-1:0]       mult_B,
  input  logic                  mult_Done,
  input  logic [RES_W-1:0]      mult_Result,
  output arb_state_t            state_dbg
);

  if (N_REQ < 2 || N_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mult_share_arbiter: N_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_t        state, state_nxt;
  logic [2:0]        last_grant;
  logic              done_q;
  logic [N_REQ-1:0]  pick_gnt;
  logic [2:0]        pick_idx;
  logic              pick_any;
  logic              grant_en;
  logic              cmpl;
  logic              to_hit;
  logic [OP_W-1:0]   sel_a, sel_b;

  rr_pick #(.N(N_REQ)) u_pick (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (pick_gnt[i]) begin
        sel_a = req_a[OP_W*i +: OP_W];
        sel_b = req_b[OP_W*i +: OP_W];
      end
    end
  end

  // Completion is the rising edge of mult_Done; a level left high from the
  // previous op must neither complete this op nor allow a new grant.
  assign cmpl = (state == S_WAIT) && mult_Done && !done_q;

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    case (state)
      S_IDLE: begin
        if (pick_any && !mult_Done) begin
          grant_en  = 1'b1;
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT:  if (cmpl || to_hit) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= 3'(N_REQ - 1);
      done_q     <= 1'b0;
      grant_id   <= '0;
      mult_A     <= '0;
      mult_B     <= '0;
      rsp_result <= '0;
    end else begin
      state  <= state_nxt;
      done_q <= mult_Done;
      if (grant_en) begin
        grant_id <= pick_idx;
        mult_A   <= sel_a;
        mult_B   <= sel_b;
      end
      if (cmpl) rsp_result <= mult_Result;
      else if (to_hit) rsp_result <= '0;
      if (state == S_RESP) last_grant <= grant_id;
    end
  end

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt;
  logic             rsp_err_q;

  assign to_hit = (state == S_WAIT) && !cmpl &&
                  (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge Clk or posedge rst) begin
    if (rst) begin
      wait_cnt  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE) wait_cnt <= '0;
      else if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (cmpl) rsp_err_q <= 1'b0;
      else if (to_hit) rsp_err_q <= 1'b1;
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign to_hit  = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // Handshake: req_valid is a level held by the requester until it sees its
  // req_ready bit, which pulses for exactly the one IDLE cycle in which the
  // operands are taken; rsp_valid pulses once, in RESP, for that requester.
  assign req_ready = (grant_en && !rst) ? pick_gnt : '0;
  assign rsp_valid = (state == S_RESP) ? (N_REQ'(1) << grant_id) : '0;
  assign mult_St   = (state == S_ISSUE);
  assign busy      = (state != S_IDLE);
  assign state_dbg = state;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter with a behavioural multiplier of latency L.
module tb_mult_share_arbiter;
  import mult_arb_pkg::*;

  localparam int N   = 4;
  localparam int L   = 4;
  localparam int TMO = 8;

  logic          Clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [8*N-1:0] req_a, req_b;
  logic [N-1:0]  req_ready, rsp_valid;
  logic [15:0]   rsp_result;
  logic          rsp_err, busy, mult_St, mult_Done;
  logic [2:0]    grant_id;
  logic [7:0]    mult_A, mult_B;
  logic [15:0]   mult_Result;
  arb_state_t    state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int hold_extra;
  bit never_done;

  mult_share_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk         (Clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .busy        (busy),
    .grant_id    (grant_id),
    .mult_St     (mult_St),
    .mult_A      (mult_A),
    .mult_B      (mult_B),
    .mult_Done   (mult_Done),
    .mult_Result (mult_Result),
    .state_dbg   (state_dbg)
  );

  // clock / reset-independent watchdog
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural multiplier: Done rises L+1 cycles after the St cycle and is
  // held for 1+hold_extra cycles.
  int          m_cnt;
  int          hold_cnt;
  logic [15:0] prod;

  always @(posedge Clk or posedge rst) begin
    if (rst) begin
      m_cnt       <= 0;
      hold_cnt    <= 0;
      prod        <= '0;
      mult_Done   <= 1'b0;
      mult_Result <= '0;
    end else begin
      if (mult_St) begin
        m_cnt <= L;
        prod  <= 16'(mult_A) * 16'(mult_B);
      end else if (m_cnt > 0) begin
        m_cnt <= m_cnt - 1;
      end
      if (m_cnt == 1 && !never_done) begin
        mult_Done   <= 1'b1;
        mult_Result <= prod;
        hold_cnt    <= hold_extra;
      end else if (mult_Done) begin
        if (hold_cnt > 0) hold_cnt <= hold_cnt - 1;
        else mult_Done <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req_ready"},  32'(req_ready),  32'h0);
    chk({tag, "_rsp_valid"},  32'(rsp_valid),  32'h0);
    chk({tag, "_rsp_result"}, 32'(rsp_result), 32'h0);
    chk({tag, "_rsp_err"},    32'(rsp_err),    32'h0);
    chk({tag, "_busy"},       32'(busy),       32'h0);
    chk({tag, "_grant_id"},   32'(grant_id),   32'h0);
    chk({tag, "_mult_St"},    32'(mult_St),    32'h0);
    chk({tag, "_mult_A"},     32'(mult_A),     32'h0);
    chk({tag, "_mult_B"},     32'(mult_B),     32'h0);
    chk({tag, "_state"},      32'(state_dbg),  32'(S_IDLE));
  endtask

  // Called in the low phase of the first cycle to inspect; returns in the
  // low phase of the response cycle (or after the bound expires).
  task automatic op(input string tag, input logic [N-1:0] exp_oh, input logic [15:0] exp_res,
                    input logic exp_err, input int exp_lat, output int idle_wait);
    int cyc;
    int st_cnt;
    idle_wait = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (req_ready != '0) break;
      idle_wait++;
      @(negedge Clk);
    end
    chk({tag, "_req_ready"}, 32'(req_ready), 32'(exp_oh));
    cyc    = -1;
    st_cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge Clk);
      #1;
      if (mult_St) st_cnt++;
      if (rsp_valid != '0) begin
        cyc = i;
        break;
      end
    end
    chk({tag, "_rsp_valid"}, 32'(rsp_valid),  32'(exp_oh));
    chk({tag, "_result"},    32'(rsp_result), 32'(exp_res));
    chk({tag, "_err"},       32'(rsp_err),    32'(exp_err));
    chk({tag, "_latency"},   32'(cyc),        32'(exp_lat));
    chk({tag, "_st_pulses"}, 32'(st_cnt),     32'd1);
  endtask

  initial begin
    int w;
    int n_rsp;
    rst        = 1'b1;
    hold_extra = 0;
    never_done = 1'b0;
    req_valid  = 4'b0100;
    req_a      = 32'h000C_0000;
    req_b      = 32'h000A_0000;

    // reset state, with a request already pending
    @(negedge Clk); #1;
    chk_reset("por");

    // single request from requester 2: 0x0C * 0x0A
    @(negedge Clk);
    rst = 1'b0;
    op("single", 4'b0100, 16'h0078, 1'b0, L + 3, w);
    chk("single_wait", 32'(w), 32'd0);
    chk("single_gid", 32'(grant_id), 32'd2);
    chk("single_A", 32'(mult_A), 32'h0C);
    chk("single_B", 32'(mult_B), 32'h0A);
    req_valid = '0;
    @(negedge Clk); #1;
    chk("single_no_2nd_rsp", 32'(rsp_valid), 32'h0);
    chk("single_idle", 32'(busy), 32'h0);

    // extremes
    @(negedge Clk);
    req_valid      = 4'b1000;
    req_a[31:24]   = 8'h00;
    req_b[31:24]   = 8'hAB;
    op("zero_op", 4'b1000, 16'h0000, 1'b0, L + 3, w);
    req_valid = '0;
    @(negedge Clk);
    req_valid      = 4'b0010;
    req_a[15:8]    = 8'hFF;
    req_b[15:8]    = 8'hFF;
    op("ff_ff", 4'b0010, 16'hFE01, 1'b0, L + 3, w);
    req_valid = '0;

    // reset during WAIT
    @(negedge Clk);
    req_valid  = 4'b0001;
    req_a[7:0] = 8'h11;
    req_b[7:0] = 8'h22;
    #1;
    chk("mid_ready", 32'(req_ready), 32'h1);
    @(negedge Clk);
    req_valid = '0;
    @(negedge Clk);
    @(negedge Clk); #1;
    chk("mid_busy", 32'(busy), 32'h1);
    chk("mid_state", 32'(state_dbg), 32'(S_WAIT));
    chk("mid_prev_result", 32'(rsp_result), 32'hFE01);
    rst       = 1'b1;
    req_valid = 4'b0001;
    #1;
    chk_reset("mid_rst");
    @(negedge Clk); #1;
    chk_reset("mid_rst_hold");
    @(negedge Clk);
    rst       = 1'b0;
    req_valid = '0;
    n_rsp     = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk); #1;
      if (rsp_valid != '0) n_rsp++;
    end
    chk("mid_no_rsp", 32'(n_rsp), 32'd0);

    // all requesters continuously valid: A=i+1, B=0x10
    @(negedge Clk);
    req_valid = 4'hF;
    req_a     = 32'h0403_0201;
    req_b     = 32'h1010_1010;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clk);
      op($sformatf("rr%0d", i), 4'(1 << (i % 4)), 16'((i % 4 + 1) * 16), 1'b0, L + 3, w);
      chk($sformatf("rr%0d_wait", i), 32'(w), 32'd0);
    end

    // Done held high 3 extra cycles while requester 1 is pending
    req_valid  = 4'b1000;
    hold_extra = 3;
    @(negedge Clk);
    op("hold", 4'b1000, 16'h0040, 1'b0, L + 3, w);
    chk("hold_wait", 32'(w), 32'd0);
    req_valid  = 4'b0010;
    hold_extra = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk); #1;
      chk($sformatf("hold_gate%0d_ready", i), 32'(req_ready), 32'h0);
      chk($sformatf("hold_gate%0d_rsp", i), 32'(rsp_valid), 32'h0);
      chk($sformatf("hold_gate%0d_busy", i), 32'(busy), 32'h0);
    end
    @(negedge Clk);
    op("after_hold", 4'b0010, 16'h0020, 1'b0, L + 3, w);
    chk("after_hold_wait", 32'(w), 32'd0);
    req_valid = '0;

`ifdef MULT_ARB_TIMEOUT_EN
    // multiplier never completes: abort after TMO WAIT cycles
    @(negedge Clk);
    req_valid  = 4'b0100;
    never_done = 1'b1;
    op("tmo", 4'b0100, 16'h0000, 1'b1, TMO + 2, w);
    req_valid  = '0;
    never_done = 1'b0;
    @(negedge Clk); #1;
    chk("tmo_err_held", 32'(rsp_err), 32'h1);
    @(negedge Clk);
    req_valid = 4'b0100;
    op("post_tmo", 4'b0100, 16'h0030, 1'b0, L + 3, w);
    req_valid = '0;
`endif

    @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
# mult_share_arbiter

Round-robin arbiter and sequencer that shares one `eightbit_pipmultiplier` instance between `N_REQ` requesters. It accepts one 8x8 unsigned multiply request at a time and drives the multiplier's start/operand inputs. It then waits for completion and returns the 16-bit product to the winning requester with a one-cycle response pulse. It sits between the multiplier and the client blocks, and it is the only driver of the multiplier's inputs.

## Interface
- `N_REQ`, default 4, number of requesters (2..8).
- `TIMEOUT_CYCLES`, default 64, watchdog limit in WAIT; used only when the timeout macro is defined.
- `Clk`  in  1  clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request, level; held until accepted.
- `req_a`, `req_b`  in  8*N_REQ  packed operands; requester i uses bits [8i+7:8i].
- `req_ready`  out  N_REQ  one-hot, one-cycle accept pulse.
- `rsp_valid`  out  N_REQ  one-hot, one-cycle response pulse to the granted requester.
- `rsp_result`  out  16  product; valid while any `rsp_valid` bit is high, held otherwise.
- `rsp_err`  out  1  response is a timeout abort; always 0 when the macro is not defined.
- `busy`  out  1  high in every state except IDLE.
- `grant_id`  out  3  index of the current or most recent grant.
- `mult_St`  out  1  multiplier start.
- `mult_A`, `mult_B`  out  8  multiplier operands.
- `mult_Done`  in  1  multiplier completion.
- `mult_Result`  in  16  multiplier product.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE, grant condition: `req_valid` != 0 and `mult_Done` == 0.
  - Pick the first valid requester at or after `(last_grant+1) mod N_REQ`, wrapping.
  - Pulse `req_ready[g]`, latch `req_a`/`req_b` slice g into `mult_A`/`mult_B`, set `grant_id`=g, go to ISSUE.
- IDLE while `mult_Done` is still high (completion from the previous op not yet dropped): no grant.
- ISSUE: `mult_St`=1 for exactly one cycle; go to WAIT.
- WAIT: `mult_St`=0. `mult_A`/`mult_B` are held constant from the latch cycle until RESP exits.
- Completion = rising edge of `mult_Done`, i.e. `mult_Done` & ~`done_q`, where `done_q` is a registered copy.
- On completion: capture `mult_Result` into `rsp_result`, go to RESP.
- RESP: `rsp_valid[g]`=1 for one cycle, update `last_grant`=g, go to IDLE.
- Requests are never dropped. A request that deasserts before acceptance is simply not granted; requesters must not do this.
- Products are unsigned. 0xFF*0xFF = 0xFE01. Any operand of 0 gives 0x0000.
- Reset, including mid-operation: state IDLE, `last_grant`=N_REQ-1 (so requester 0 wins first).
  - All outputs 0: `mult_St`, `mult_A`, `mult_B`, `req_ready`, `rsp_valid`, `rsp_result`, `rsp_err`, `busy`, `grant_id`, `done_q`.
  - No response is issued for an aborted operation.

## Timing
- Cycle 0: request sampled in IDLE, `req_ready` pulses.
- Cycle 1: ISSUE, `mult_St` high.
- WAIT lasts until the cycle after `mult_Done` rises, i.e. the multiplier latency L.
- RESP occurs 1 cycle after the completion edge is seen.
- Total request-to-response latency: L+3 cycles.
- Next grant: earliest in the cycle after RESP, gated by `mult_Done` low.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,...,N_REQ-1,0. No requester waits more than N_REQ-1 operations.
- A new `req_valid` arriving during a non-IDLE state is only considered in IDLE.

## Configuration
- `MULT_ARB_TIMEOUT_EN` defined:
  - A WAIT-state counter starts at 0 on entry.
  - If it reaches `TIMEOUT_CYCLES` without a completion edge: go to RESP with `rsp_result`=0 and `rsp_err`=1.
  - Round-robin pointer updates normally.
  - `rsp_err` returns to 0 on the next RESP that completes normally.
- `MULT_ARB_TIMEOUT_EN` not defined: no counter, WAIT is unbounded, `rsp_err` tied 0.

## Structure
- Shared package `mult_arb_pkg`:
  - FSM state enum (IDLE/ISSUE/WAIT/RESP).
  - Operand width 8, result width 16.
  - Default `TIMEOUT_CYCLES`.
- One sub-module, `rr_pick`: combinational round-robin priority selector (request vector + last grant → one-hot grant + index), reused by other shared-resource arbiters.
- The multiplier is instantiated outside this block; the bench pairs it with the real multiplier or a behavioural model with configurable L.

## Test plan
- Single request: requester 2, A=0x0C, B=0x0A → one `req_ready[2]` pulse, one `mult_St` pulse, `rsp_valid[2]` with 0x0078 exactly L+3 cycles after acceptance.
- All 4 requesting continuously with A=i+1, B=0x10 → grant order 0,1,2,3,0; results 0x0010, 0x0020, 0x0030, 0x0040.
- Extremes: A=0xFF, B=0xFF → 0xFE01; A=0x00, B=0xAB → 0x0000; `rsp_err`=0.
- `rst` asserted mid-WAIT → all outputs 0 asynchronously, no `rsp_valid`; after release, requester 0 wins first.
- Model holds `mult_Done` high 3 cycles after completion while requester 1 is pending → no grant until `mult_Done` falls; exactly one response per operation.
- With `MULT_ARB_TIMEOUT_EN`, TIMEOUT_CYCLES=8, model never asserts Done → RESP after 8 WAIT cycles, `rsp_result`=0, `rsp_err`=1; the next normal op clears `rsp_err`.
